// File: rtl/dma_tlp_tx_if.sv
// dma_tlp_tx_if: 64-bit TRN transmit bus between the TLP builder and the
// PCIe endpoint core.
//   trn_td         64  beat data, [63:32] is the first DW on the wire
//   trn_trem_n      8  8'h00 both DWs valid, 8'h0F upper DW only
//   trn_tsof_n      1  start of frame, active low
//   trn_teof_n      1  end of frame, active low
//   trn_tsrc_rdy_n  1  source has a beat, active low
//   trn_tdst_rdy_n  1  core takes the beat, active low
// master = TLP source, slave = endpoint core.
interface dma_tlp_tx_if;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;

    modport master (
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        input  trn_tdst_rdy_n
    );

    modport slave (
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        output trn_tdst_rdy_n
    );
endinterface

// File: rtl/dma_tlp_tx.sv
// dma_tlp_tx: builds one PCIe Memory Write TLP (3DW header, 32-bit address)
// per dma_start and streams TLP_SIZE_DW payload DWs from a FWFT FIFO onto
// the 64-bit TRN transmit bus.
// Ports:
//   trn_clk, trn_rst        clock, asynchronous active-high reset
//   dma_start, dma_addr     start request and DW address [31:2] of the TLP
//   dma_rd_en               registered payload window back to the DMA SM
//   stream_on               low blocks new starts
//   cfg_bus_mstr_enable     low blocks new starts
//   cfg_completer_id        requester ID placed in header DW1
//   fifo_dout, fifo_empty   FWFT FIFO head word ([63:32] earlier DW), empty
//   fifo_rd_en              FIFO pop strobe
//   trn                     TRN transmit bus (master side)
//   tlp_count               completed TLPs, wraps
//   fifo_underflow          sticky: pop issued while FIFO was empty
module dma_tlp_tx #(
    parameter int TLP_SIZE_DW = 32
) (
    input  logic               trn_clk,
    input  logic               trn_rst,
    input  logic               dma_start,
    input  logic [29:0]        dma_addr,
    output logic               dma_rd_en,
    input  logic               stream_on,
    input  logic               cfg_bus_mstr_enable,
    input  logic [15:0]        cfg_completer_id,
    input  logic [63:0]        fifo_dout,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    dma_tlp_tx_if.master       trn,
    output logic [31:0]        tlp_count,
    output logic               fifo_underflow
);

    localparam int BEATS = TLP_SIZE_DW / 2;
    localparam int CW    = $clog2(BEATS) + 1;
    // Payload beats remaining after the HDR1 pop.
    localparam logic [CW-1:0] CNT_LOAD = CW'(BEATS - 1);
    // MWr, 3DW header, no data digest, TC0, attr 0, length in DW.
    localparam logic [31:0] HDR_DW0 = 32'h4000_0000 | {22'h0, 10'(TLP_SIZE_DW)};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        PAYLOAD = 3'd3,
        LAST    = 3'd4,
        GAP     = 3'd5
    } state_t;

    state_t          state_r;
    state_t          next_s;
    logic [29:0]     addr_r;
    logic [31:0]     held_r;
    logic [CW-1:0]   cnt_r;
    logic [31:0]     tlp_count_r;
    logic            underflow_r;
    logic            rd_en_r;

    logic [63:0]     td_s;
    logic [7:0]      trem_s;
    logic            sof_s;
    logic            eof_s;
    logic            src_rdy_s;
    logic            pop_s;
    logic            start_s;
    logic            done_s;

    // State register.
    always_ff @(posedge trn_clk or posedge trn_rst) begin
        if (trn_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state and TRN beat decode. Beat outputs depend only on state,
    // the holding register and the FIFO head, so they hold under stall.
    always_comb begin
        next_s    = state_r;
        td_s      = 64'h0;
        trem_s    = 8'h00;
        sof_s     = 1'b1;
        eof_s     = 1'b1;
        src_rdy_s = 1'b1;
        pop_s     = 1'b0;
        start_s   = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (dma_start && stream_on && cfg_bus_mstr_enable) begin
                    start_s = 1'b1;
                    next_s  = HDR0;
                end else begin
                    next_s  = IDLE;
                end
            end
            HDR0: begin
                src_rdy_s = 1'b0;
                sof_s     = 1'b0;
                td_s      = {HDR_DW0, cfg_completer_id, 8'h00, 4'hF, 4'hF};
                if (!trn.trn_tdst_rdy_n) begin
                    next_s = HDR1;
                end else begin
                    next_s = HDR0;
                end
            end
            HDR1: begin
                src_rdy_s = 1'b0;
                td_s      = {addr_r, 2'b00, fifo_dout[63:32]};
                if (!trn.trn_tdst_rdy_n) begin
                    pop_s = 1'b1;
                    if (CNT_LOAD == {CW{1'b0}}) begin
                        next_s = LAST;
                    end else begin
                        next_s = PAYLOAD;
                    end
                end else begin
                    next_s = HDR1;
                end
            end
            PAYLOAD: begin
                src_rdy_s = 1'b0;
                td_s      = {held_r, fifo_dout[63:32]};
                if (!trn.trn_tdst_rdy_n) begin
                    pop_s = 1'b1;
                    // This pop is the last one when one beat remains.
                    if (cnt_r == CW'(1)) begin
                        next_s = LAST;
                    end else begin
                        next_s = PAYLOAD;
                    end
                end else begin
                    next_s = PAYLOAD;
                end
            end
            LAST: begin
                src_rdy_s = 1'b0;
                eof_s     = 1'b0;
                trem_s    = 8'h0F;
                td_s      = {held_r, 32'h0000_0000};
                if (!trn.trn_tdst_rdy_n) begin
                    done_s = 1'b1;
                    next_s = GAP;
                end else begin
                    next_s = LAST;
                end
            end
            GAP: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // Datapath: address latch, odd-DW holding register, beat counter,
    // statistics and the payload window.
    always_ff @(posedge trn_clk or posedge trn_rst) begin
        if (trn_rst) begin
            addr_r      <= 30'h0;
            held_r      <= 32'h0;
            cnt_r       <= {CW{1'b0}};
            tlp_count_r <= 32'h0;
            underflow_r <= 1'b0;
            rd_en_r     <= 1'b0;
        end else begin
            if (start_s) begin
                addr_r <= dma_addr;
            end
            if (pop_s) begin
                held_r <= fifo_dout[31:0];
                cnt_r  <= (state_r == HDR1) ? CNT_LOAD : (cnt_r - CW'(1));
            end
            if (pop_s && fifo_empty) begin
                underflow_r <= 1'b1;
            end
            if (done_s) begin
                tlp_count_r <= tlp_count_r + 32'd1;
            end
            // High exactly while in HDR1/PAYLOAD, stalls included.
            rd_en_r <= (next_s == HDR1) || (next_s == PAYLOAD);
        end
    end

    assign trn.trn_td         = td_s;
    assign trn.trn_trem_n     = trem_s;
    assign trn.trn_tsof_n     = sof_s;
    assign trn.trn_teof_n     = eof_s;
    assign trn.trn_tsrc_rdy_n = src_rdy_s;
    assign fifo_rd_en         = pop_s;
    assign dma_rd_en          = rd_en_r;
    assign tlp_count          = tlp_count_r;
    assign fifo_underflow     = underflow_r;

endmodule

// File: tb/tb_dma_tlp_tx.sv
module tb_dma_tlp_tx;

    typedef struct packed {
        logic [63:0] td;
        logic [7:0]  trem;
        logic        sof;
        logic        eof;
    } beat_t;

    typedef struct {
        logic [29:0] addr;
        logic [15:0] id;
        logic [31:0] pb;
        int          stall;
        int          gate;
        int          exp_beats;
        int          exp_pops;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stream_on, bme;
    logic [15:0] cid;
    always #5 clk = ~clk;

    // 32-DW instance
    logic        dma_start, dma_rd_en, fifo_empty, fifo_rd_en, fifo_underflow;
    logic [29:0] dma_addr;
    logic [63:0] fifo_dout;
    logic [31:0] tlp_count;
    logic [31:0] pbase;
    int          rd_ptr = 0, base_ptr = 0;
    dma_tlp_tx_if tif();

    // 2-DW instance
    logic        dma_start2, dma_rd_en2, fifo_rd_en2, fifo_underflow2;
    logic [29:0] dma_addr2;
    logic [63:0] fifo_dout2;
    logic [31:0] tlp_count2;
    logic [31:0] pbase2;
    int          rd_ptr2 = 0;
    dma_tlp_tx_if tif2();

    dma_tlp_tx #(.TLP_SIZE_DW(32)) dut (
        .trn_clk(clk), .trn_rst(rst), .dma_start(dma_start), .dma_addr(dma_addr),
        .dma_rd_en(dma_rd_en), .stream_on(stream_on), .cfg_bus_mstr_enable(bme),
        .cfg_completer_id(cid), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .trn(tif), .tlp_count(tlp_count),
        .fifo_underflow(fifo_underflow)
    );

    dma_tlp_tx #(.TLP_SIZE_DW(2)) dut2 (
        .trn_clk(clk), .trn_rst(rst), .dma_start(dma_start2), .dma_addr(dma_addr2),
        .dma_rd_en(dma_rd_en2), .stream_on(stream_on), .cfg_bus_mstr_enable(bme),
        .cfg_completer_id(cid), .fifo_dout(fifo_dout2), .fifo_empty(1'b0),
        .fifo_rd_en(fifo_rd_en2), .trn(tif2), .tlp_count(tlp_count2),
        .fifo_underflow(fifo_underflow2)
    );

    // FIFO models: word j of the current TLP is {P(2j), P(2j+1)}, P(k) = base + k.
    assign fifo_dout  = {pbase + 32'(2 * (rd_ptr - base_ptr)), pbase + 32'(2 * (rd_ptr - base_ptr) + 1)};
    assign fifo_dout2 = {pbase2 + 32'(2 * rd_ptr2), pbase2 + 32'(2 * rd_ptr2 + 1)};

    always @(posedge clk) begin
        if (fifo_rd_en)  rd_ptr  <= rd_ptr + 1;
        if (fifo_rd_en2) rd_ptr2 <= rd_ptr2 + 1;
    end

    // Bus monitors
    beat_t beats[$];
    beat_t beats2[$];
    int sof_cnt = 0, src_low_cnt = 0, rd_rises = 0, rd_falls = 0, rd_high = 0, bubbles = 0;
    logic rd_prev = 1'b0, in_frame = 1'b0;

    always @(negedge clk) begin
        if (!tif.trn_tsrc_rdy_n && !tif.trn_tdst_rdy_n) begin
            beats.push_back({tif.trn_td, tif.trn_trem_n, tif.trn_tsof_n, tif.trn_teof_n});
            if (!tif.trn_tsof_n) sof_cnt++;
        end
        if (!tif.trn_tsrc_rdy_n) src_low_cnt++;
        if (rst) in_frame = 1'b0;
        else begin
            if (in_frame && tif.trn_tsrc_rdy_n) bubbles++;
            if (!tif.trn_tsrc_rdy_n && !tif.trn_tdst_rdy_n && !tif.trn_tsof_n) in_frame = 1'b1;
            if (!tif.trn_tsrc_rdy_n && !tif.trn_tdst_rdy_n && !tif.trn_teof_n) in_frame = 1'b0;
        end
        if (dma_rd_en && !rd_prev) rd_rises++;
        if (!dma_rd_en && rd_prev) rd_falls++;
        if (dma_rd_en) rd_high++;
        rd_prev = dma_rd_en;
        if (!tif2.trn_tsrc_rdy_n && !tif2.trn_tdst_rdy_n)
            beats2.push_back({tif2.trn_td, tif2.trn_trem_n, tif2.trn_tsof_n, tif2.trn_teof_n});
    end

    int n_chk = 0, n_pass = 0, exp_tlps = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: beat i of an n-DW MWr TLP built from the field rules.
    function automatic beat_t model(int i, int n, logic [29:0] a, logic [15:0] id, logic [31:0] pb);
        beat_t b;
        int last = n / 2 + 1;
        b.sof  = (i == 0) ? 1'b0 : 1'b1;
        b.eof  = (i == last) ? 1'b0 : 1'b1;
        b.trem = (i == last) ? 8'h0F : 8'h00;
        if (i == 0)         b.td = {32'h4000_0000 + 32'(n), id, 8'h00, 8'hFF};
        else if (i == 1)    b.td = {a, 2'b00, pb};
        else if (i == last) b.td = {pb + 32'(n - 1), 32'h0};
        else                b.td = {pb + 32'(2 * i - 3), pb + 32'(2 * i - 2)};
        return b;
    endfunction

    // One TLP on the 32-DW instance, optionally gated at the start and stalled.
    task automatic run_tlp(input logic [29:0] a, input logic [15:0] id, input logic [31:0] pb,
                           input int stall, input int gate, input int exp_beats, input int exp_pops);
        int b0, s0, r0, f0, h0, sl0, bub0, nb, k, done, seen;
        beat_t e;
        b0 = beats.size(); s0 = sof_cnt; r0 = rd_rises; f0 = rd_falls;
        h0 = rd_high; sl0 = src_low_cnt; bub0 = bubbles;
        pbase = pb; base_ptr = rd_ptr; cid = id; dma_addr = a;
        tif.trn_tdst_rdy_n = 1'b0;
        if (gate == 1) stream_on = 1'b0;
        if (gate == 2) bme = 1'b0;
        dma_start = 1'b1;
        if (gate != 0) begin
            repeat (20) @(posedge clk);
            #1;
            chk("gate_idle", {beats.size() - b0, src_low_cnt - sl0, rd_ptr - base_ptr, rd_rises - r0},
                128'h0);
            stream_on = 1'b1; bme = 1'b1;
            seen = 0;
            for (int c = 0; c < 2; c++) begin
                @(posedge clk); #1;
                if (!tif.trn_tsof_n) begin seen = 1; break; end
            end
            chk("gate_start", seen, 1);
        end
        done = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (dma_rd_en) dma_start = 1'b0;
            tif.trn_tdst_rdy_n = (stall > 0) && (int'($urandom_range(99, 0)) < stall);
            if (beats.size() > b0 && beats[$].eof == 1'b0) begin done = 1; break; end
        end
        tif.trn_tdst_rdy_n = 1'b0;
        dma_start = 1'b0;
        chk("tlp_done", done, 1);
        if (done) exp_tlps++;
        nb = beats.size() - b0;
        chk("beat_count", nb, exp_beats);
        k = -1;
        for (int i = 0; i < nb; i++) begin
            e = model(i, 32, a, id, pb);
            if (beats[b0 + i] !== e && k < 0) k = i;
        end
        if (nb > 0) begin
            if (k < 0) k = nb - 1;
            chk("beat_data", beats[b0 + k], model(k, 32, a, id, pb));
        end
        chk("pops", rd_ptr - base_ptr, exp_pops);
        chk("rd_en_window", {rd_rises - r0, rd_falls - f0, sof_cnt - s0, bubbles - bub0},
            {32'd1, 32'd1, 32'd1, 32'd0});
        if (stall == 0) chk("rd_en_len", rd_high - h0, 16);
        chk("tlp_count", tlp_count, exp_tlps);
    endtask

    vec_t vecs[5];

    initial begin
        int b0, n, s0, done2;
        vecs[0] = '{30'h0400_0000, 16'h0100, 32'h0000_0000, 0,  0, 18, 16};
        vecs[1] = '{30'h0400_0020, 16'hBEEF, 32'h0000_1000, 50, 0, 18, 16};
        vecs[2] = '{30'h3FFF_FFE0, 16'h0001, 32'hFFFF_FFF0, 80, 0, 18, 16};
        vecs[3] = '{30'h0000_0100, 16'h1234, 32'h0000_0055, 0,  1, 18, 16};
        vecs[4] = '{30'h0000_0200, 16'h4321, 32'h0000_0077, 30, 2, 18, 16};

        rst = 1'b1; stream_on = 1'b1; bme = 1'b1; cid = 16'h0;
        dma_start = 1'b0; dma_addr = 30'h0; fifo_empty = 1'b0; pbase = 32'h0;
        dma_start2 = 1'b0; dma_addr2 = 30'h0; pbase2 = 32'h0;
        tif.trn_tdst_rdy_n = 1'b0; tif2.trn_tdst_rdy_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vals", {tif.trn_td, tif.trn_trem_n, tif.trn_tsof_n, tif.trn_teof_n, tif.trn_tsrc_rdy_n,
                           dma_rd_en, fifo_rd_en, tlp_count, fifo_underflow},
            {64'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0});
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors
        b0 = beats.size();
        for (int v = 0; v < 5; v++)
            run_tlp(vecs[v].addr, vecs[v].id, vecs[v].pb, vecs[v].stall, vecs[v].gate,
                    vecs[v].exp_beats, vecs[v].exp_pops);
        if (beats.size() >= b0 + 18) begin
            chk("beat0_const", beats[b0].td, 64'h4000_0020_0100_00FF);
            chk("beat1_const", beats[b0 + 1].td, 64'h1000_0000_0000_0000);
            chk("beat17_const", {beats[b0 + 17].td, beats[b0 + 17].trem, beats[b0 + 17].eof},
                {64'h0000_001F_0000_0000, 8'h0F, 1'b0});
        end else chk("beats_present", beats.size() - b0, 90);

        // Back-to-back: 4 TLPs at consecutive 128-byte addresses.
        s0 = sof_cnt; n = exp_tlps;
        for (int t = 0; t < 4; t++)
            run_tlp(30'h0100_0000 + 30'(32 * t), 16'h00A5, $urandom, 0, 0, 18, 16);
        chk("b2b", {sof_cnt - s0, tlp_count - 32'(n)}, {32'd4, 32'd4});

        // Randomized TLPs
        for (int t = 0; t < 6; t++)
            run_tlp(30'($urandom), 16'($urandom), $urandom, int'($urandom_range(70, 0)), 0, 18, 16);

        // Reset in the middle of the payload.
        b0 = beats.size(); pbase = 32'h0000_0900; base_ptr = rd_ptr;
        dma_addr = 30'h0000_5000; dma_start = 1'b1; done2 = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (dma_rd_en) dma_start = 1'b0;
            if (rd_ptr - base_ptr == 5) begin done2 = 1; break; end
        end
        chk("rst_reach", done2, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid", {tif.trn_td, tif.trn_trem_n, tif.trn_tsof_n, tif.trn_teof_n, tif.trn_tsrc_rdy_n,
                        dma_rd_en, fifo_rd_en, tlp_count, fifo_underflow},
            {64'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0});
        dma_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; exp_tlps = 0;
        n = 0;
        for (int i = b0; i < beats.size(); i++) if (beats[i].eof == 1'b0) n++;
        chk("rst_no_eof", n, 0);
        @(posedge clk); #1;
        run_tlp(30'h0000_6000, 16'h0707, 32'h0000_0A00, 20, 0, 18, 16);

        // Empty FIFO: underflow sets, TLP still completes.
        chk("underflow_clear", fifo_underflow, 1'b0);
        fifo_empty = 1'b1;
        run_tlp(30'h0000_7000, 16'h0808, 32'h0000_0B00, 0, 0, 18, 16);
        fifo_empty = 1'b0;
        chk("underflow_set", fifo_underflow, 1'b1);

        // 2-DW instance: three beats, one pop.
        b0 = beats2.size(); s0 = rd_ptr2;
        pbase2 = 32'hA000_0000 - 32'(2 * rd_ptr2);
        cid = 16'h0C0D; dma_addr2 = 30'h0000_1234; dma_start2 = 1'b1; done2 = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (dma_rd_en2) dma_start2 = 1'b0;
            if (beats2.size() > b0 && beats2[$].eof == 1'b0) begin done2 = 1; break; end
        end
        dma_start2 = 1'b0;
        chk("s2_done", done2, 1);
        chk("s2_beats", beats2.size() - b0, 3);
        for (int i = 0; i < 3 && b0 + i < beats2.size(); i++)
            chk("s2_beat", beats2[b0 + i], model(i, 2, 30'h0000_1234, 16'h0C0D, 32'hA000_0000));
        chk("s2_pops", rd_ptr2 - s0, 1);
        chk("s2_count", tlp_count2, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dma_tlp_tx.md
Name: dma_tlp_tx

Overview:
- Transmit engine on the downstream side of the DMA state machine's start/read-enable handshake.
- On each dma_start it builds one PCIe Memory Write TLP: 3DW header, 32-bit address.
- Payload is streamed from the ADC data FIFO onto the 64-bit TRN transmit interface of the endpoint core.
- dma_rd_en is returned as a contiguous payload window, so the DMA state machine detects start of payload (rising edge) and end of TLP (falling edge).

Parameters:
TLP_SIZE_DW, 32, payload length in DW; even, 2..32; must equal the DMA state machine's DMA_TLP_SIZE increment.

Ports:
trn_clk  in  1  TRN clock; all logic on rising edge
trn_rst  in  1  asynchronous active-high reset
dma_start  in  1  level request from DMA SM; held until dma_rd_en seen high
dma_addr  in  30  DW address [31:2] of the TLP; stable while dma_start high
dma_rd_en  out  1  payload window to DMA SM
stream_on  in  1  low blocks acceptance of new starts
cfg_bus_mstr_enable  in  1  PCIe bus-master enable
cfg_completer_id  in  16  requester ID for header
fifo_dout  in  64  FWFT FIFO data, [63:32] = earlier DW
fifo_empty  in  1  FIFO empty
fifo_rd_en  out  1  FIFO pop strobe
trn_td  out  64  TRN data, [63:32] = first DW on bus
trn_trem_n  out  8  00 = both DW valid; 0F = upper DW only
trn_tsof_n  out  1  start of frame, active low
trn_teof_n  out  1  end of frame, active low
trn_tsrc_rdy_n  out  1  source ready, active low
trn_tdst_rdy_n  in  1  destination ready, active low
tlp_count  out  32  TLPs completed, wraps
fifo_underflow  out  1  sticky: pop attempted while fifo_empty

Behaviour:
- Reset values: dma_rd_en=0, fifo_rd_en=0, trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_td=0, trn_trem_n=0, tlp_count=0, fifo_underflow=0, state IDLE.
- Beat acceptance: a beat is accepted in any cycle with trn_tsrc_rdy_n=0 and trn_tdst_rdy_n=0. When trn_tdst_rdy_n=1, trn_td, trn_trem_n, trn_tsof_n, trn_teof_n and the state all hold, and fifo_rd_en=0.
- trn_tsrc_rdy_n stays low continuously from HDR0 through LAST; no source bubbles inside a TLP.
- Header DW0 = 0x4000_0000 | TLP_SIZE_DW[9:0]: MWr 3DW, TC0, TD0, EP0, attr 0.
- Header DW1 = {cfg_completer_id, 8'h00, 4'hF, 4'hF}.
- Header DW2 = {addr_latched, 2'b00}.
- FIFO word j = {P(2j), P(2j+1)}. A low-DW holding register carries P(2j+1) into the next beat.
- States:
  - IDLE: trn_tsrc_rdy_n=1. If dma_start & stream_on & cfg_bus_mstr_enable: latch dma_addr, go to HDR0. If cfg_bus_mstr_enable=0, the start is ignored and dma_rd_en never rises.
  - HDR0: drive {DW0,DW1}, tsof_n=0, trem_n=00. On accept go to HDR1.
  - HDR1: drive {DW2, fifo_dout[63:32]}, dma_rd_en=1. On accept: pop, hold fifo_dout[31:0], beat counter = TLP_SIZE_DW/2-1. Go to PAYLOAD, or to LAST if counter=0.
  - PAYLOAD: drive {held, fifo_dout[63:32]}. On accept: pop, reload holding register, decrement counter; at 0 go to LAST.
  - LAST: drive {held, 32'h0}, trem_n=0F, teof_n=0, dma_rd_en=0. No pop. On accept: tlp_count+1, go to GAP.
  - GAP: one cycle, tsrc_rdy_n=1, then IDLE. Guarantees dma_rd_en low for at least 2 cycles before a new TLP, and lets the DMA SM update dma_addr and re-raise dma_start.
- dma_rd_en is registered: high from entry to HDR1 until entry to LAST, and never toggles inside the window, including during stalls.
- Pop counts: exactly TLP_SIZE_DW/2 pops per TLP; TLP length TLP_SIZE_DW/2+2 beats.
- A pop with fifo_empty=1 sets fifo_underflow (cleared only by reset). The TLP is still completed with fifo_dout as presented.
- stream_on falling mid-TLP: the current TLP completes fully; no new start is accepted.
- cfg_bus_mstr_enable falling mid-TLP: the current TLP also completes.
- Reset mid-TLP: immediate return to reset values, with no teof.

Test Plan:
- Single TLP, dma_addr=0x0400_0000 (byte address 0x1000_0000), FIFO words {2j,2j+1}, tdst_rdy_n=0 → 18 beats. Beat0 = 0x40000020_{id}00FF, beat1 = 0x10000000_00000000, beat17 = {0x1F, x} with trem_n=0F and teof_n=0. 16 pops; dma_rd_en high for exactly 16 cycles.
- Backpressure: toggle trn_tdst_rdy_n pseudo-randomly → data matches the unstalled beat sequence, pop count stays 16, dma_rd_en stays one contiguous pulse.
- Back-to-back: dma_start re-raised 1 cycle after dma_rd_en falls, 4 TLPs → tlp_count=4, second header DW2 = previous+128 bytes, tsof exactly 4 times.
- Gating: cfg_bus_mstr_enable=0 or stream_on=0 with dma_start=1 for 20 cycles → no TRN activity, no pops. Enabling then starts a TLP within 2 cycles.
- Reset: assert trn_rst in PAYLOAD beat 5 → all outputs at reset values in the same cycle; next start produces a complete TLP. Also empty FIFO at HDR1 → fifo_underflow=1.
- TLP_SIZE_DW=2 → 3 beats: {DW0,DW1}, {addr,P0}, {P1,x} with trem_n=0F; exactly 1 pop.
